wb_hilo_stage: RTL and testbench

//  Write-back stage: consumer end of the MEM/WB pipeline register. Picks register-file

---
 rtl/wb_hilo_stage_if.sv | 48 ++++
 rtl/wb_hilo_stage.sv | 130 +++++++++++++
 tb/tb_wb_hilo_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_hilo_stage_if.sv
// ----------------------------------------------------------------------------
// wb_hilo_stage_if
// Bundles the MEM/WB pipeline-register outputs consumed by the write-back
// stage, together with the write-back results it produces.
//   master : drives the MEM/WB fields, observes the RF write port, the HI/LO
//            bypass values and the retire counter
//   slave  : the write-back stage itself
// Signals:
//   WB_Valid, WB_RegWrite, WB_MemtoReg, WB_ReadData, WB_ALUResult,
//   WB_RegDstData, WB_HI, WB_LO, WB_RType, func_in      (master -> slave)
//   RF_WriteEn, RF_WriteAddr, RF_WriteData, HI_Fwd, LO_Fwd,
//   RetireCount                                         (slave -> master)
// ----------------------------------------------------------------------------
interface wb_hilo_stage_if #(
    parameter int CNT_W = 32
);
    logic             WB_Valid;
    logic             WB_RegWrite;
    logic             WB_MemtoReg;
    logic [31:0]      WB_ReadData;
    logic [31:0]      WB_ALUResult;
    logic [4:0]       WB_RegDstData;
    logic [31:0]      WB_HI;
    logic [31:0]      WB_LO;
    logic             WB_RType;
    logic [5:0]       func_in;

    logic             RF_WriteEn;
    logic [4:0]       RF_WriteAddr;
    logic [31:0]      RF_WriteData;
    logic [31:0]      HI_Fwd;
    logic [31:0]      LO_Fwd;
    logic [CNT_W-1:0] RetireCount;

    modport master (
        output WB_Valid, WB_RegWrite, WB_MemtoReg, WB_ReadData, WB_ALUResult,
               WB_RegDstData, WB_HI, WB_LO, WB_RType, func_in,
        input  RF_WriteEn, RF_WriteAddr, RF_WriteData, HI_Fwd, LO_Fwd,
               RetireCount
    );

    modport slave (
        input  WB_Valid, WB_RegWrite, WB_MemtoReg, WB_ReadData, WB_ALUResult,
               WB_RegDstData, WB_HI, WB_LO, WB_RType, func_in,
        output RF_WriteEn, RF_WriteAddr, RF_WriteData, HI_Fwd, LO_Fwd,
               RetireCount
    );
endinterface

// File: rtl/wb_hilo_stage.sv
// ----------------------------------------------------------------------------
// wb_hilo_stage
// Write-back stage at the consumer end of the MEM/WB register. Selects the
// register-file write data (load word, ALU result, or HI/LO for mfhi/mflo),
// suppresses writes to $0, owns the architectural HI/LO registers, provides
// the HI/LO values EX must use this cycle, and counts retired instructions.
// Ports:
//   Clk  : clock, all state changes on the rising edge
//   Clr  : asynchronous active-high reset of HI/LO and the retire counter
//   wb   : slave side of wb_hilo_stage_if (MEM/WB fields in, RF write port,
//          HI/LO bypass and RetireCount out)
// The RF write port and HI/LO bypass are combinational so the register file
// and EX see this cycle's result with zero latency.
// ----------------------------------------------------------------------------
module wb_hilo_stage #(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Clr,
    wb_hilo_stage_if.slave   wb
);

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_MFHI   = 3'd1,
        OP_MTHI   = 3'd2,
        OP_MFLO   = 3'd3,
        OP_MTLO   = 3'd4,
        OP_MULDIV = 3'd5
    } hilo_op_e;

    hilo_op_e         op_s;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      hi_next_s;
    logic [31:0]      lo_next_s;
    logic [CNT_W-1:0] cnt_r;

    // Decode the HI/LO operation; bubbles and non-SPECIAL opcodes never touch HI/LO.
    always_comb begin
        op_s = OP_NONE;
        if (wb.WB_Valid && wb.WB_RType) begin
            case (wb.func_in)
                6'h10:   op_s = OP_MFHI;
                6'h11:   op_s = OP_MTHI;
                6'h12:   op_s = OP_MFLO;
                6'h13:   op_s = OP_MTLO;
                6'h18,
                6'h19,
                6'h1A,
                6'h1B:   op_s = OP_MULDIV;
                default: op_s = OP_NONE;
            endcase
        end else begin
            op_s = OP_NONE;
        end
    end

    // Value HI/LO will hold after the coming edge.
    always_comb begin
        hi_next_s = hi_r;
        lo_next_s = lo_r;
        case (op_s)
            OP_MULDIV: begin
                hi_next_s = wb.WB_HI;
                lo_next_s = wb.WB_LO;
            end
            OP_MTHI: hi_next_s = wb.WB_ALUResult;
            OP_MTLO: lo_next_s = wb.WB_ALUResult;
            default: begin
                hi_next_s = hi_r;
                lo_next_s = lo_r;
            end
        endcase
    end

    // Bypass to EX; forced to zero while reset is held so EX never sees stale state.
    always_comb begin
        if (Clr) begin
            wb.HI_Fwd = 32'h0;
            wb.LO_Fwd = 32'h0;
        end else begin
            wb.HI_Fwd = hi_next_s;
            wb.LO_Fwd = lo_next_s;
        end
    end

    // Register-file write port; mfhi/mflo read the committed registers, and a
    // write in flight during reset is discarded.
    always_comb begin
        wb.RF_WriteAddr = wb.WB_RegDstData;
        wb.RF_WriteEn   = 1'b0;
        if (!Clr && wb.WB_Valid && wb.WB_RegWrite && (wb.WB_RegDstData != 5'd0)) begin
            wb.RF_WriteEn = 1'b1;
        end else begin
            wb.RF_WriteEn = 1'b0;
        end
        case (op_s)
            OP_MFHI: wb.RF_WriteData = hi_r;
            OP_MFLO: wb.RF_WriteData = lo_r;
            default: begin
                if (wb.WB_MemtoReg) begin
                    wb.RF_WriteData = wb.WB_ReadData;
                end else begin
                    wb.RF_WriteData = wb.WB_ALUResult;
                end
            end
        endcase
    end

    // Architectural HI/LO and the retire counter (wraps silently).
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            hi_r  <= 32'h0;
            lo_r  <= 32'h0;
            cnt_r <= '0;
        end else begin
            hi_r <= hi_next_s;
            lo_r <= lo_next_s;
            if (wb.WB_Valid) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign wb.RetireCount = cnt_r;

endmodule

// File: tb/tb_wb_hilo_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_hilo_stage
// Directed bench for wb_hilo_stage. A 32-bit-counter instance and a 4-bit-
// counter instance receive identical stimulus. A behavioural model of HI/LO
// and the retire count is checked against both instances every cycle, and
// literal expectations pin the model at key points.
// ----------------------------------------------------------------------------
module tb_wb_hilo_stage;

    logic Clk = 1'b0;
    logic Clr = 1'b1;

    int total = 0;
    int bad   = 0;

    wb_hilo_stage_if #(.CNT_W(32)) ifc ();
    wb_hilo_stage_if #(.CNT_W(4))  ifs ();

    wb_hilo_stage #(.CNT_W(32)) dut (.Clk(Clk), .Clr(Clr), .wb(ifc.slave));
    wb_hilo_stage #(.CNT_W(4))  dut_small (.Clk(Clk), .Clr(Clr), .wb(ifs.slave));

    always #5 Clk = ~Clk;

    // model state
    logic [31:0] hi_m = 32'h0;
    logic [31:0] lo_m = 32'h0;
    logic [31:0] cnt_m = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit is_op(input logic [5:0] f);
        return ifc.WB_Valid && ifc.WB_RType && (ifc.func_in == f);
    endfunction

    function automatic bit is_muldiv();
        return ifc.WB_Valid && ifc.WB_RType &&
               (ifc.func_in >= 6'h18) && (ifc.func_in <= 6'h1B);
    endfunction

    // model update at each edge (or reset)
    always @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            hi_m  <= 32'h0;
            lo_m  <= 32'h0;
            cnt_m <= 32'h0;
        end else begin
            if (is_muldiv()) begin
                hi_m <= ifc.WB_HI;
                lo_m <= ifc.WB_LO;
            end
            if (is_op(6'h11)) hi_m <= ifc.WB_ALUResult;
            if (is_op(6'h13)) lo_m <= ifc.WB_ALUResult;
            if (ifc.WB_Valid) cnt_m <= cnt_m + 32'd1;
        end
    end

    // compare process: every falling edge
    always @(negedge Clk) begin
        logic [31:0] e_hi, e_lo, e_data;
        logic        e_en;
        e_hi = hi_m;
        e_lo = lo_m;
        if (is_muldiv()) begin
            e_hi = ifc.WB_HI;
            e_lo = ifc.WB_LO;
        end
        if (is_op(6'h11)) e_hi = ifc.WB_ALUResult;
        if (is_op(6'h13)) e_lo = ifc.WB_ALUResult;
        if (Clr) begin
            e_hi = 32'h0;
            e_lo = 32'h0;
        end
        e_en = !Clr && ifc.WB_Valid && ifc.WB_RegWrite && (ifc.WB_RegDstData != 5'd0);
        if (is_op(6'h10))      e_data = hi_m;
        else if (is_op(6'h12)) e_data = lo_m;
        else if (ifc.WB_MemtoReg) e_data = ifc.WB_ReadData;
        else                   e_data = ifc.WB_ALUResult;
        check("cyc_hi_fwd", ifc.HI_Fwd, e_hi);
        check("cyc_lo_fwd", ifc.LO_Fwd, e_lo);
        check("cyc_we", {31'd0, ifc.RF_WriteEn}, {31'd0, e_en});
        check("cyc_waddr", {27'd0, ifc.RF_WriteAddr}, {27'd0, ifc.WB_RegDstData});
        check("cyc_wdata", ifc.RF_WriteData, e_data);
        check("cyc_count", ifc.RetireCount, cnt_m);
        check("cyc_count4", {28'd0, ifs.RetireCount}, {28'd0, cnt_m[3:0]});
    end

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [31:0] rd, input logic [31:0] alu,
                         input logic [4:0] dst, input logic [31:0] hi,
                         input logic [31:0] lo, input logic rt, input logic [5:0] fn);
        ifc.WB_Valid = v;     ifs.WB_Valid = v;
        ifc.WB_RegWrite = rw; ifs.WB_RegWrite = rw;
        ifc.WB_MemtoReg = m2r; ifs.WB_MemtoReg = m2r;
        ifc.WB_ReadData = rd; ifs.WB_ReadData = rd;
        ifc.WB_ALUResult = alu; ifs.WB_ALUResult = alu;
        ifc.WB_RegDstData = dst; ifs.WB_RegDstData = dst;
        ifc.WB_HI = hi;       ifs.WB_HI = hi;
        ifc.WB_LO = lo;       ifs.WB_LO = lo;
        ifc.WB_RType = rt;    ifs.WB_RType = rt;
        ifc.func_in = fn;     ifs.func_in = fn;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 6'h00);
        tick();
        tick();
        Clr = 1'b0;
        #1;
        check("rst_count", ifc.RetireCount, 32'd0);
        check("rst_hi", ifc.HI_Fwd, 32'd0);
        check("rst_lo", ifc.LO_Fwd, 32'd0);
        check("rst_we", {31'd0, ifc.RF_WriteEn}, 32'd0);
        tick();

        // MULT then mfhi/mflo
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 6'h18);
        check("mult_hi_fwd", ifc.HI_Fwd, 32'h1234_5678);
        check("mult_lo_fwd", ifc.LO_Fwd, 32'h9ABC_DEF0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h5555, 5'd8, 32'h0, 32'h0, 1'b1, 6'h10);
        check("mfhi_we", {31'd0, ifc.RF_WriteEn}, 32'd1);
        check("mfhi_addr", {27'd0, ifc.RF_WriteAddr}, 32'd8);
        check("mfhi_data", ifc.RF_WriteData, 32'h1234_5678);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h5555, 5'd9, 32'h0, 32'h0, 1'b1, 6'h12);
        check("mflo_data", ifc.RF_WriteData, 32'h9ABC_DEF0);
        tick();

        // MTLO then MTHI
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'd5, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 6'h13);
        check("mtlo_lo", ifc.LO_Fwd, 32'd5);
        check("mtlo_hi", ifc.HI_Fwd, 32'h1234_5678);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 6'h11);
        check("mthi_hi", ifc.HI_Fwd, 32'hDEAD_BEEF);
        check("mthi_lo", ifc.LO_Fwd, 32'd5);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 6'h00);
        check("zero_hi", ifc.HI_Fwd, 32'hDEAD_BEEF);
        check("zero_lo", ifc.LO_Fwd, 32'd5);
        tick();

        // loads and ALU writes
        drive(1'b1, 1'b1, 1'b1, 32'hCAFE, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 6'h00);
        check("ld_r0_we", {31'd0, ifc.RF_WriteEn}, 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'hCAFE, 32'h1111, 5'd3, 32'h0, 32'h0, 1'b0, 6'h00);
        check("ld_r3_we", {31'd0, ifc.RF_WriteEn}, 32'd1);
        check("ld_r3_data", ifc.RF_WriteData, 32'h0000_CAFE);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'hCAFE, 32'd7, 5'd3, 32'h0, 32'h0, 1'b0, 6'h00);
        check("alu_data", ifc.RF_WriteData, 32'd7);
        tick();

        // bubble carrying junk
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h77, 5'd5, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b1, 6'h18);
        check("bub_we", {31'd0, ifc.RF_WriteEn}, 32'd0);
        check("bub_hi", ifc.HI_Fwd, 32'hDEAD_BEEF);
        check("bub_lo", ifc.LO_Fwd, 32'd5);
        tick();
        check("bub_count", ifc.RetireCount, 32'd8);
        // valid R-type func 0 must leave HI/LO alone
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h3, 5'd4, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b1, 6'h00);
        check("f0_hi", ifc.HI_Fwd, 32'hDEAD_BEEF);
        check("f0_lo", ifc.LO_Fwd, 32'd5);
        tick();
        check("f0_count", ifc.RetireCount, 32'd9);

        // reset asserted mid-cycle with a write pending
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h9, 5'd4, 32'h1, 32'h2, 1'b1, 6'h18);
        Clr = 1'b1;
        #1;
        check("clr_hi", ifc.HI_Fwd, 32'd0);
        check("clr_lo", ifc.LO_Fwd, 32'd0);
        check("clr_count", ifc.RetireCount, 32'd0);
        check("clr_we", {31'd0, ifc.RF_WriteEn}, 32'd0);
        tick();
        check("clr_hold_count", ifc.RetireCount, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 6'h00);
        Clr = 1'b0;
        tick();

        // 17 valid instructions: 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0, 32'(i), 5'(i + 1), 32'h0, 32'h0, 1'b0, 6'h00);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 6'h00);
        check("wrap_count4", {28'd0, ifs.RetireCount}, 32'd1);
        check("wrap_count32", ifc.RetireCount, 32'd17);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
